// File: rtl/rf_window_sequencer.sv
// rf_window_sequencer: walks the output grid of a D x H x W image for an
// F x F filter with stride S and presents N horizontally adjacent receptive
// fields per ready/valid beat, together with the row/column indices, a lane
// mask and a last-beat flag.
module rf_window_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int S          = 1,
    parameter int N          = 14,
    parameter int IDX_W      = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [D*H*W*DATA_WIDTH-1:0]     image,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N*D*F*F*DATA_WIDTH-1:0]   receptive_field,
    output logic [IDX_W-1:0]                row_index,
    output logic [IDX_W-1:0]                col_index,
    output logic [N-1:0]                    lane_mask,
    output logic                            last,
    output logic                            done
);

    localparam int OH        = (H - F) / S + 1;
    localparam int OW        = (W - F) / S + 1;
    localparam int G         = (OW + N - 1) / N;
    localparam int FW        = D * F * F;          // words per field
    localparam int IMG_WORDS = D * H * W;
    localparam int OUT_WORDS = N * FW;
    localparam int PIX_AW    = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    if (((H - F) % S) != 0 || ((W - F) % S) != 0 || F > H || F > W) begin : g_bad_cfg
        $error("rf_window_sequencer: filter/stride do not tile the image");
    end

    logic [0:0]            state;
    logic [IDX_W-1:0]      r;
    logic [IDX_W-1:0]      g;
    logic                  is_final;
    logic                  load_beat;
    logic [IDX_W-1:0]      load_r;
    logic [IDX_W-1:0]      load_g;
    logic [PIX_AW-1:0]     src;
    logic [N-1:0]          nxt_mask;
    logic [N*FW*DATA_WIDTH-1:0] nxt_field;
    logic [DATA_WIDTH-1:0] pix       [IMG_WORDS];
    logic [DATA_WIDTH-1:0] nxt_words [OUT_WORDS];

    // Word 0 of the image sits at the MSB end of the flat vector.
    for (genvar p = 0; p < IMG_WORDS; p++) begin : g_pix
        assign pix[p] = image[(IMG_WORDS-1-p)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Lane 0, word 0 of the outgoing beat sits at the MSB end.
    for (genvar q = 0; q < OUT_WORDS; q++) begin : g_pack
        assign nxt_field[(OUT_WORDS-1-q)*DATA_WIDTH +: DATA_WIDTH] = nxt_words[q];
    end

    // Choose which (row, group) gets loaded at the next edge: (0,0) when a
    // frame starts, otherwise the successor of the beat being accepted.
    always_comb begin
        is_final  = (r == IDX_W'(OH - 1)) && (g == IDX_W'(G - 1));
        load_beat = (state == ST_IDLE) ? start : (out_ready && !is_final);
        if (state == ST_IDLE || is_final) begin
            load_r = '0;
            load_g = '0;
        end else if (g == IDX_W'(G - 1)) begin
            load_r = r + 1'b1;
            load_g = '0;
        end else begin
            load_r = r;
            load_g = g + 1'b1;
        end
    end

    // Gather the N receptive fields for the beat about to be loaded.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional write, otherwise the tool infers a latch for the
        // paths that skip the assignment.
        src      = '0;
        nxt_mask = '0;
        for (int q = 0; q < OUT_WORDS; q++) begin
            nxt_words[q] = '0;
        end
        for (int j = 0; j < N; j++) begin
            if (int'(load_g) * N + j < OW) begin
                nxt_mask[j] = 1'b1;
                for (int k = 0; k < D; k++) begin
                    for (int i = 0; i < F; i++) begin
                        for (int x = 0; x < F; x++) begin
                            src = PIX_AW'(k*H*W + (int'(load_r)*S + i)*W
                                          + (int'(load_g)*N + j)*S + x);
                            nxt_words[j*FW + k*F*F + i*F + x] = pix[src];
                        end
                    end
                end
            end
        end
    end

    // Frame control: state, counters and handshake flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state     <= ST_IDLE;
            r         <= '0;
            g         <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    state     <= ST_RUN;
                    busy      <= 1'b1;
                    out_valid <= 1'b1;
                end
            end else if (out_ready) begin
                if (is_final) begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end
            end
            if (load_beat) begin
                r <= load_r;
                g <= load_g;
            end
        end
    end

    // Beat registers: loaded only on start or accept so they hold under stall.
    always_ff @(posedge clk) begin
        // NOTE: the wide field register is reset on purpose -- its value is
        // visible on the ports straight after reset and must read as zero.
        if (reset) begin
            receptive_field <= '0;
            row_index       <= '0;
            col_index       <= '0;
            lane_mask       <= '0;
            last            <= 1'b0;
        end else if (load_beat) begin
            receptive_field <= nxt_field;
            row_index       <= load_r;
            col_index       <= IDX_W'(int'(load_g) * N);
            lane_mask       <= nxt_mask;
            last            <= (load_r == IDX_W'(OH - 1)) && (load_g == IDX_W'(G - 1));
        end else if (state == ST_RUN && out_ready && is_final) begin
            last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_window_sequencer.sv
// Testbench for rf_window_sequencer: three parameter sets side by side, one
// observed at a time through a mux, checked against a scoreboard of beats
// generated from the image coordinates.
`timescale 1ns/1ps
module tb_rf_window_sequencer;

    localparam int DW    = 16;
    localparam int FBITS = 288;   // 18 words per beat in every configuration
    localparam int FWRD  = FBITS / DW;

    typedef struct packed {
        logic [FBITS-1:0] field;
        logic [5:0]       row;
        logic [5:0]       col;
        logic [1:0]       mask;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, out_ready;

    // Config A: D=1 H=W=6 F=3 S=1 N=2
    logic [36*DW-1:0] img_a;
    logic             a_busy, a_valid, a_last, a_done;
    logic [FBITS-1:0] a_field;
    logic [5:0]       a_row, a_col;
    logic [1:0]       a_mask;
    // Config B: D=1 H=W=7 F=3 S=2 N=2
    logic [49*DW-1:0] img_b;
    logic             b_busy, b_valid, b_last, b_done;
    logic [FBITS-1:0] b_field;
    logic [5:0]       b_row, b_col;
    logic [1:0]       b_mask;
    // Config C: D=2 H=W=4 F=3 S=1 N=1
    logic [32*DW-1:0] img_c;
    logic             c_busy, c_valid, c_last, c_done;
    logic [FBITS-1:0] c_field;
    logic [5:0]       c_row, c_col;
    logic [0:0]       c_mask;

    rf_window_sequencer #(.DATA_WIDTH(DW), .D(1), .H(6), .W(6), .F(3), .S(1), .N(2), .IDX_W(6)) u_a (
        .clk(clk), .reset(reset), .start(start), .image(img_a), .busy(a_busy),
        .out_valid(a_valid), .out_ready(out_ready), .receptive_field(a_field),
        .row_index(a_row), .col_index(a_col), .lane_mask(a_mask), .last(a_last), .done(a_done));

    rf_window_sequencer #(.DATA_WIDTH(DW), .D(1), .H(7), .W(7), .F(3), .S(2), .N(2), .IDX_W(6)) u_b (
        .clk(clk), .reset(reset), .start(start), .image(img_b), .busy(b_busy),
        .out_valid(b_valid), .out_ready(out_ready), .receptive_field(b_field),
        .row_index(b_row), .col_index(b_col), .lane_mask(b_mask), .last(b_last), .done(b_done));

    rf_window_sequencer #(.DATA_WIDTH(DW), .D(2), .H(4), .W(4), .F(3), .S(1), .N(1), .IDX_W(6)) u_c (
        .clk(clk), .reset(reset), .start(start), .image(img_c), .busy(c_busy),
        .out_valid(c_valid), .out_ready(out_ready), .receptive_field(c_field),
        .row_index(c_row), .col_index(c_col), .lane_mask(c_mask), .last(c_last), .done(c_done));

    int               sel;
    logic             m_busy, m_valid, m_last, m_done;
    logic [FBITS-1:0] m_field;
    logic [5:0]       m_row, m_col;
    logic [1:0]       m_mask;

    always_comb begin
        m_busy = a_busy; m_valid = a_valid; m_last = a_last; m_done = a_done;
        m_field = a_field; m_row = a_row; m_col = a_col; m_mask = a_mask;
        if (sel == 1) begin
            m_busy = b_busy; m_valid = b_valid; m_last = b_last; m_done = b_done;
            m_field = b_field; m_row = b_row; m_col = b_col; m_mask = b_mask;
        end else if (sel == 2) begin
            m_busy = c_busy; m_valid = c_valid; m_last = c_last; m_done = c_done;
            m_field = c_field; m_row = c_row; m_col = c_col; m_mask = {1'b0, c_mask};
        end
    end

    int    n_checks = 0;
    int    n_errors = 0;
    int    n_acc    = 0;
    int    cyc_cnt  = 0;
    bit    mon_en   = 1'b0;
    bit    exp_done_pend = 1'b0;
    beat_t sb[$];

    task automatic check(input string tag, input logic [FBITS-1:0] act, input logic [FBITS-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic get_cfg(input int s_sel, output int d, output int h, output int w,
                           output int f, output int s, output int n);
        case (s_sel)
            1:       begin d = 1; h = 7; w = 7; f = 3; s = 2; n = 2; end
            2:       begin d = 2; h = 4; w = 4; f = 3; s = 1; n = 1; end
            default: begin d = 1; h = 6; w = 6; f = 3; s = 1; n = 2; end
        endcase
    endtask

    // Pixel value at channel k, image row y, column x: 100*k + y*W + x.
    task automatic push_frame(input int s_sel);
        int    d, h, w, f, s, n, oh, ow, gg, fw, c, q;
        beat_t b;
        get_cfg(s_sel, d, h, w, f, s, n);
        oh = (h - f) / s + 1;
        ow = (w - f) / s + 1;
        gg = (ow + n - 1) / n;
        fw = d * f * f;
        for (int r = 0; r < oh; r++) begin
            for (int g = 0; g < gg; g++) begin
                b.field = '0;
                b.mask  = '0;
                b.row   = 6'(r);
                b.col   = 6'(g * n);
                b.last  = (r == oh - 1) && (g == gg - 1);
                for (int j = 0; j < n; j++) begin
                    c = g * n + j;
                    if (c < ow) begin
                        b.mask[j] = 1'b1;
                        for (int k = 0; k < d; k++)
                            for (int i = 0; i < f; i++)
                                for (int x = 0; x < f; x++) begin
                                    q = j * fw + k * f * f + i * f + x;
                                    b.field[(FWRD-1-q)*DW +: DW] =
                                        DW'(k * 100 + (r * s + i) * w + c * s + x);
                                end
                    end
                end
                sb.push_back(b);
            end
        end
    endtask

    function automatic logic [FBITS-1:0] pack18(input int v [FWRD]);
        logic [FBITS-1:0] res;
        res = '0;
        for (int q = 0; q < FWRD; q++) res[(FWRD-1-q)*DW +: DW] = DW'(v[q]);
        return res;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Monitor: compares the presented beat with the scoreboard head every
    // cycle (so stalled beats must match too) and pops it on acceptance.
    initial forever begin
        beat_t e;
        @(negedge clk);
        if (mon_en) begin
            check("done", FBITS'(m_done), FBITS'(exp_done_pend));
            if (exp_done_pend) begin
                check("busy_after_done", FBITS'(m_busy), FBITS'(0));
                check("valid_after_done", FBITS'(m_valid), FBITS'(0));
                exp_done_pend = 1'b0;
            end
            if (m_valid) begin
                if (sb.size() == 0) begin
                    check("extra_beat", FBITS'(m_valid), FBITS'(0));
                end else begin
                    e = sb[0];
                    check("field", m_field, e.field);
                    check("row_index", FBITS'(m_row), FBITS'(e.row));
                    check("col_index", FBITS'(m_col), FBITS'(e.col));
                    check("lane_mask", FBITS'(m_mask), FBITS'(e.mask));
                    check("last", FBITS'(m_last), FBITS'(e.last));
                    check("busy", FBITS'(m_busy), FBITS'(1));
                    if (out_ready) begin
                        n_acc++;
                        if (e.last) exp_done_pend = 1'b1;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        exp_done_pend = 1'b0;
        @(negedge clk);
        check("rst_valid", FBITS'(m_valid), FBITS'(0));
        check("rst_busy", FBITS'(m_busy), FBITS'(0));
        check("rst_last", FBITS'(m_last), FBITS'(0));
        check("rst_done", FBITS'(m_done), FBITS'(0));
        check("rst_field", m_field, FBITS'(0));
        check("rst_row", FBITS'(m_row), FBITS'(0));
        check("rst_col", FBITS'(m_col), FBITS'(0));
        check("rst_mask", FBITS'(m_mask), FBITS'(0));
        mon_en = 1'b1;
    endtask

    // Pulse start, then expect the first beat exactly one cycle later.
    task automatic start_frame(output int t0);
        push_frame(sel);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc_cnt;
        @(negedge clk);
        check("first_beat_latency", FBITS'(m_valid), FBITS'(1));
    endtask

    // mode 0: always ready; mode 1: random ready. start pulsed at pulse_at.
    task automatic run_frame(input int mode, input int pulse_at, output int t_done);
        bit seen;
        seen   = 1'b0;
        t_done = 0;
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (m_done) begin
                seen   = 1'b1;
                t_done = cyc_cnt;
            end else begin
                out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                start     = (cyc == pulse_at);
            end
        end
        start = 1'b0;
        check("frame_done_seen", FBITS'(seen), FBITS'(1));
        check("scoreboard_empty", FBITS'(sb.size()), FBITS'(0));
    endtask

    initial begin
        int t0, t1, base;
        int lit_a [FWRD] = '{0, 1, 2, 6, 7, 8, 12, 13, 14, 1, 2, 3, 7, 8, 9, 13, 14, 15};
        int lit_c [FWRD] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 100, 101, 102, 104, 105, 106, 108, 109, 110};

        for (int p = 0; p < 36; p++) img_a[(35-p)*DW +: DW] = DW'(p);
        for (int p = 0; p < 49; p++) img_b[(48-p)*DW +: DW] = DW'(p);
        for (int p = 0; p < 32; p++) img_c[(31-p)*DW +: DW] = DW'((p / 16) * 100 + p % 16);

        sel = 0; reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame at full throughput.
        sel = 0;
        do_reset();
        out_ready = 1'b1;
        start_frame(t0);
        check("a_beat0_literal", m_field, pack18(lit_a));
        run_frame(0, -1, t1);
        check("a_frame_cycles", FBITS'(t1 - t0), FBITS'(8));

        // Backpressure with a stray start mid-frame, then start on done.
        do_reset();
        start_frame(t0);
        run_frame(1, 3, t1);
        out_ready = 1'b1;
        start_frame(t0);
        run_frame(0, -1, t1);
        check("a_restart_cycles", FBITS'(t1 - t0), FBITS'(8));

        // Reset while the fifth beat is stalled.
        do_reset();
        out_ready = 1'b1;
        base = n_acc;
        start_frame(t0);
        for (int i = 0; i < 50; i++) begin
            if (n_acc - base >= 4) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("a_beats_before_reset", FBITS'(n_acc - base), FBITS'(4));
        @(negedge clk);
        check("a_stalled_valid", FBITS'(m_valid), FBITS'(1));
        @(posedge clk); #1;
        do_reset();
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        start_frame(t0);
        run_frame(0, -1, t1);

        // Stride 2 with a partially filled second group.
        sel = 1;
        do_reset();
        start_frame(t0);
        run_frame(1, -1, t1);

        // Two channels, one lane.
        sel = 2;
        do_reset();
        out_ready = 1'b1;
        start_frame(t0);
        check("c_beat0_literal", m_field, pack18(lit_c));
        run_frame(0, -1, t1);
        check("c_frame_cycles", FBITS'(t1 - t0), FBITS'(4));

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
